fifo_rd_deframer: RTL and testbench
===================================

Name: fifo_rd_deframer

Overview:
- Read-side drain stage for the async FIFO. Sits in the FIFO read clock domain and connects to the FIFO rdata/rempty/rinc.
- Pops words from the FIFO and parses them into packets. Each packet is one header word followed by LEN payload words.
- Presents packets as a valid/ready flit stream with sop/eop/dest sideband to the downstream router port.
- A 2-entry output skid buffer sustains 1 word/cycle with a registered rinc path.

Parameters:
- DSIZE, 32, FIFO word / flit width.
- LENW, 8, width of the header length field (header bits [LENW-1:0]).
- DESTW, 4, width of the header dest field (header bits [DSIZE-1:DSIZE-DESTW]).
- MAX_LEN, 16, maximum legal payload length in words.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  synchronous reset, active-high.
- rdata  in  DSIZE  FIFO head word; valid when rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO pop strobe.
- out_data  out  DSIZE  flit data.
- out_valid  out  1  flit valid.
- out_ready  in  1  downstream accept.
- out_sop  out  1  flit is a packet header.
- out_eop  out  1  flit is the last of its packet.
- out_dest  out  DESTW  dest of the current packet, held for all its flits.
- err_len  out  1  1-cycle pulse: header dropped because LEN > MAX_LEN.
- pkt_cnt  out  16  count of packets fully delivered (eop handshakes), wraps.

Behaviour:
Interface and reset:
- One clock (rclk). Reset rrst is synchronous and active-high.
- Reset values: rinc=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_dest=0, err_len=0, pkt_cnt=0, skid buffer empty, FSM=HDR.
- Reset mid-packet discards buffered flits and partial-packet state. No rinc is issued while rrst=1.

FIFO side and handshakes:
- FIFO read is combinational (rdata valid while rempty=0). A pop happens on the rclk edge where rinc=1.
- rinc = !rempty && !rrst && (skid occupancy < 2, counting entries leaving this cycle).
- A dropped header (err_len case) pops without consuming buffer space.
- Latency: a word at the FIFO head in cycle N with rinc=1 is visible on out_* in cycle N+1, provided the buffer was empty.
- Throughput: with out_ready held at 1, one flit per cycle.
- Output handshake happens when out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data/sop/eop/dest are stable. out_valid never drops without a handshake.
- The skid buffer is a 2-entry FIFO of {data, sop, eop, dest}. Simultaneous push and pop keeps occupancy unchanged.

FSM (advances on each popped word):
- HDR state:
  - Popped word is a header. LEN = word[LENW-1:0], DEST = word[DSIZE-1:DSIZE-DESTW].
  - If LEN > MAX_LEN: no flit pushed, err_len=1 next cycle, stay in HDR.
  - Otherwise push the header flit with sop=1, eop=(LEN==0), dest=DEST.
  - If LEN != 0: remaining = LEN, go to PAY.
- PAY state:
  - Each popped word is pushed with sop=0, dest=latched DEST, and remaining decremented.
  - eop=1 when remaining==1 before the decrement; that pop returns the FSM to HDR.
  - remaining is LENW bits wide. It never underflows because LEN <= MAX_LEN and the FSM exits at 1.
- Back-to-back packets need no idle cycles: the word after an eop pop is parsed as a header.
- rempty asserted mid-packet: FSM holds state and remaining, and out_valid drops once the buffer drains. This is legal; the packet resumes when data arrives.

pkt_cnt and err_len:
- pkt_cnt increments on each handshake with out_eop=1. It wraps 0xFFFF→0.
- err_len is a single-cycle pulse per dropped header. Consecutive bad headers produce consecutive pulses.

Decomposition:
- Shared package `noc_pkg`:
  - header field constants: DEST_MSB/LSB, LEN_MSB/LSB.
  - FSM state encoding: HDR=1'b0, PAY=1'b1.
  - flit sideband struct/bundle: {data, sop, eop, dest}, also reused by the router input port.
- One sub-module: `skid_buf2`, a generic 2-entry valid/ready buffer parameterised on width. Instantiated on the {data,sop,eop,dest} bundle. The deframer holds only the FSM, counters and rinc logic.

Test Plan:
- Single packet: FIFO holds header dest=3 LEN=2, then P0, P1; out_ready=1. Expect flits in cycles 1–3: header (sop=1, eop=0, dest=3), P0, P1 (eop=1). rinc high for 3 cycles. pkt_cnt=1.
- Zero-length and back-to-back: headers LEN=0 dest=5, then LEN=1 dest=2 + P. Expect flit 1 with sop=eop=1, then 2 flits with no bubble. pkt_cnt=2.
- Backpressure: 4-word packet, out_ready=0 for cycles 2–6. Expect at most 2 words popped while stalled, and rinc=0 once the buffer is full. Outputs stable. All 5 flits delivered in order after release, with no loss or duplication.
- Length error: header LEN=MAX_LEN+1 (17), then a valid header LEN=1. Expect an err_len pulse for 1 cycle, no flit for the bad header, then the valid packet delivered normally.
- Underflow mid-packet: rempty=1 for 4 cycles after P0 of a LEN=3 packet. Expect rinc=0 and out_valid=0 after drain, then P1 and P2 (eop=1) delivered with dest unchanged.
- Reset mid-packet: assert rrst for 1 cycle after the header pop of a LEN=4 packet. Expect all outputs at reset values, and the next popped word treated as a header.

Source files
------------

// File: rtl/fifo_rd_deframer_pkg.sv
// Shared NoC definitions: header field positions, deframer state encoding and
// the flit sideband bundle used by the deframer and router input ports.
package noc_pkg;

  localparam int unsigned DSIZE   = 32;
  localparam int unsigned LENW    = 8;
  localparam int unsigned DESTW   = 4;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNTW    = 16;

  localparam int unsigned DEST_MSB = DSIZE - 1;
  localparam int unsigned DEST_LSB = DSIZE - DESTW;
  localparam int unsigned LEN_MSB  = LENW - 1;
  localparam int unsigned LEN_LSB  = 0;

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } state_e;

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic             sop;
    logic             eop;
    logic [DESTW-1:0] dest;
  } flit_t;

  localparam int unsigned FLITW = $bits(flit_t);

endpackage

// File: rtl/fifo_rd_deframer_if.sv
// FIFO read port plus downstream flit stream seen by the deframer.
interface fifo_rd_deframer_if;
  import noc_pkg::*;

  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sop;
  logic             out_eop;
  logic [DESTW-1:0] out_dest;

  modport master (
    input  rdata, rempty, out_ready,
    output rinc, out_data, out_valid, out_sop, out_eop, out_dest
  );

  modport slave (
    output rdata, rempty, out_ready,
    input  rinc, out_data, out_valid, out_sop, out_eop, out_dest
  );

endinterface

// File: rtl/fifo_rd_deframer_skid.sv
// Generic 2-entry valid/ready buffer; head entry drives the output directly.
module skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_q0;
  logic [W-1:0] r_q1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  // r_q0 is always the head; a pop shifts r_q1 forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= i_data;
          else               r_q1 <= i_data;
          r_cnt <= 2'(r_cnt + 2'd1);
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= 2'(r_cnt - 2'd1);
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= i_data;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_q0;
  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);

endmodule

// File: rtl/fifo_rd_deframer.sv
// Read-side drain stage: pops FIFO words, splits them into header+payload
// packets and streams them out as sop/eop/dest flits through a 2-entry buffer.
module fifo_rd_deframer
  import noc_pkg::*;
(
  input  logic               rclk,
  input  logic               rrst,
  fifo_rd_deframer_if.master bus,
  output logic               err_len,
  output logic [CNTW-1:0]    pkt_cnt
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [LENW-1:0] r_rem;
  logic [LENW-1:0] w_rem_nxt;
  logic [LENW-1:0] w_len;
  logic [DESTW-1:0] r_dest;
  logic [DESTW-1:0] w_dest_nxt;
  logic [DESTW-1:0] w_hdr_dest;
  logic            r_err_len;
  logic            w_err_nxt;
  logic [CNTW-1:0] r_pkt_cnt;
  logic            w_len_bad;
  logic            w_push;
  logic            w_full;
  logic            w_valid;
  logic            w_hs;
  logic            w_rinc;
  flit_t           w_push_flit;
  flit_t           w_out;

  assign w_len      = bus.rdata[LEN_MSB:LEN_LSB];
  assign w_hdr_dest = bus.rdata[DEST_MSB:DEST_LSB];
  assign w_len_bad  = (w_len > LENW'(MAX_LEN));
  assign w_hs       = w_valid && bus.out_ready;

  // Pop whenever the buffer has room, counting the entry leaving this cycle.
  assign w_rinc   = !bus.rempty && !rrst && (!w_full || w_hs);
  assign bus.rinc = w_rinc;

  always_ff @(posedge rclk) begin
    if (rrst) r_state <= HDR;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rinc) begin
      case (r_state)
        HDR:     if (!w_len_bad && (w_len != '0)) w_state_nxt = PAY;
        PAY:     if (r_rem == LENW'(1))           w_state_nxt = HDR;
        default: w_state_nxt = HDR;
      endcase
    end
  end

  // Per-pop datapath: build the flit to push, or flag a dropped header.
  always_comb begin
    w_push      = 1'b0;
    w_push_flit = '0;
    w_rem_nxt   = r_rem;
    w_dest_nxt  = r_dest;
    w_err_nxt   = 1'b0;
    if (w_rinc) begin
      case (r_state)
        HDR: begin
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push           = 1'b1;
            w_push_flit.data = bus.rdata;
            w_push_flit.sop  = 1'b1;
            w_push_flit.eop  = (w_len == '0);
            w_push_flit.dest = w_hdr_dest;
            w_rem_nxt        = w_len;
            w_dest_nxt       = w_hdr_dest;
          end
        end
        PAY: begin
          w_push           = 1'b1;
          w_push_flit.data = bus.rdata;
          w_push_flit.eop  = (r_rem == LENW'(1));
          w_push_flit.dest = r_dest;
          w_rem_nxt        = LENW'(r_rem - LENW'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rem     <= '0;
      r_dest    <= '0;
      r_err_len <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_rem     <= w_rem_nxt;
      r_dest    <= w_dest_nxt;
      r_err_len <= w_err_nxt;
      if (w_hs && w_out.eop) r_pkt_cnt <= CNTW'(r_pkt_cnt + CNTW'(1));
    end
  end

  skid_buf2 #(
    .W(FLITW)
  ) u_skid (
    .clk     (rclk),
    .rst     (rrst),
    .i_push  (w_push),
    .i_data  (w_push_flit),
    .i_pop   (bus.out_ready),
    .o_data  (w_out),
    .o_valid (w_valid),
    .o_full  (w_full)
  );

  assign bus.out_data  = w_out.data;
  assign bus.out_sop   = w_out.sop;
  assign bus.out_eop   = w_out.eop;
  assign bus.out_dest  = w_out.dest;
  assign bus.out_valid = w_valid;
  assign err_len       = r_err_len;
  assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_rd_deframer.sv
// Bench for fifo_rd_deframer: a queue-based FIFO and packet parser predict
// every flit, err_len pulse, pop strobe and packet count cycle by cycle.
module tb_fifo_rd_deframer;

  localparam int unsigned MAXL = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  dest;
    logic        bad;
  } word_t;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        err_len;
  logic [15:0] pkt_cnt;

  fifo_rd_deframer_if bus ();

  fifo_rd_deframer dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .bus     (bus),
    .err_len (err_len),
    .pkt_cnt (pkt_cnt)
  );

  always #5 rclk = ~rclk;

  word_t       fifo_q[$];
  word_t       exp_q[$];
  int          occ;
  int unsigned exp_pkt;
  bit          exp_err;
  bit          pend_pop;
  bit          hold;
  int          n_tests;
  int          n_fail;
  int unsigned m_rem;
  logic [3:0]  m_dest;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Classify each word as it enters the FIFO, following the packet grammar.
  function automatic void push_word(input logic [31:0] w);
    word_t       e;
    int unsigned len;
    e      = '0;
    e.data = w;
    if (m_rem == 0) begin
      len = 32'(w[7:0]);
      if (len > MAXL) begin
        e.bad = 1'b1;
      end else begin
        e.sop  = 1'b1;
        e.eop  = (len == 0);
        e.dest = w[31:28];
        m_rem  = len;
        m_dest = w[31:28];
      end
    end else begin
      e.dest = m_dest;
      e.eop  = (m_rem == 1);
      m_rem  = m_rem - 1;
    end
    fifo_q.push_back(e);
  endfunction

  function automatic void add_pkt(input logic [3:0] dest, input logic [7:0] len);
    push_word({dest, 20'($urandom), len});
    if (32'(len) <= MAXL)
      for (int i = 0; i < int'(len); i++) push_word($urandom);
  endfunction

  task automatic step(input bit rdy);
    word_t       w;
    bit          exp_rinc;
    logic [37:0] got;
    logic [37:0] head;
    @(negedge rclk);
    exp_err = 1'b0;
    if (pend_pop && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      if (w.bad) exp_err = 1'b1;
      else begin
        exp_q.push_back(w);
        occ++;
      end
    end
    pend_pop      = 1'b0;
    bus.rempty    = hold || (fifo_q.size() == 0);
    bus.rdata     = (fifo_q.size() > 0) ? fifo_q[0].data : 32'h0;
    bus.out_ready = rdy;
    #1;
    check_eq("out_valid", 64'(bus.out_valid), 64'(occ != 0));
    check_eq("err_len", 64'(err_len), 64'(exp_err));
    check_eq("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    exp_rinc = !(hold || fifo_q.size() == 0) && (occ < 2 || (occ != 0 && rdy));
    check_eq("rinc", 64'(bus.rinc), 64'(exp_rinc));
    if (occ != 0) begin
      head = {exp_q[0].data, exp_q[0].sop, exp_q[0].eop, exp_q[0].dest};
      got  = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_dest};
      check_eq("flit", 64'(got), 64'(head));
      if (rdy) begin
        if (exp_q[0].eop) exp_pkt = (exp_pkt + 1) & 32'hFFFF;
        void'(exp_q.pop_front());
        occ--;
      end
    end
    pend_pop = bus.rinc;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    pend_pop      = 1'b0;
    rrst          = 1'b1;
    bus.out_ready = 1'b0;
    bus.rempty    = (fifo_q.size() == 0);
    bus.rdata     = (fifo_q.size() > 0) ? fifo_q[0].data : 32'h0;
    #1;
    check_eq("rinc_in_reset", 64'(bus.rinc), 64'd0);
    @(posedge rclk);
    #1;
    check_eq("reset_outs", 64'({bus.out_data, bus.out_valid, bus.out_sop, bus.out_eop,
                                bus.out_dest, err_len}), 64'd0);
    check_eq("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    occ        = 0;
    exp_pkt    = 0;
    exp_err    = 1'b0;
    m_rem      = 0;
    hold       = 1'b0;
    bus.rempty = 1'b1;
    rrst       = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !pend_pop) break;
      step(1'b1);
    end
    check_eq("drain_done", 64'(fifo_q.size() + exp_q.size() + int'(pend_pop)), 64'd0);
    step(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    occ           = 0;
    exp_pkt       = 0;
    exp_err       = 1'b0;
    pend_pop      = 1'b0;
    hold          = 1'b0;
    m_rem         = 0;
    m_dest        = '0;
    bus.rdata     = '0;
    bus.rempty    = 1'b1;
    bus.out_ready = 1'b0;

    do_reset();

    add_pkt(4'd3, 8'd2);
    drain();
    check_eq("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

    add_pkt(4'd5, 8'd0);
    add_pkt(4'd2, 8'd1);
    drain();
    check_eq("b2b_pkt_cnt", 64'(pkt_cnt), 64'd3);

    add_pkt(4'd7, 8'd4);
    step(1'b1);
    repeat (5) step(1'b0);
    drain();
    check_eq("bp_pkt_cnt", 64'(pkt_cnt), 64'd4);

    push_word({4'h9, 20'h0, 8'd17});
    add_pkt(4'd1, 8'd1);
    drain();
    check_eq("lenerr_pkt_cnt", 64'(pkt_cnt), 64'd5);

    push_word({4'hA, 20'h0, 8'd3});
    push_word(32'hCAFE_0000);
    repeat (6) step(1'b1);
    check_eq("underflow_idle", 64'(bus.out_valid), 64'd0);
    push_word(32'hCAFE_0001);
    push_word(32'hCAFE_0002);
    drain();
    check_eq("underflow_pkt_cnt", 64'(pkt_cnt), 64'd6);

    add_pkt(4'd6, 8'd4);
    step(1'b1);
    do_reset();
    add_pkt(4'd8, 8'd1);
    drain();
    check_eq("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd1);

    repeat (600) begin
      if (fifo_q.size() < 6)
        add_pkt(4'($urandom_range(0, 15)), 8'($urandom_range(0, 19)));
      hold = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 3) != 0);
    end
    hold = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
